// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register behind valid/ready, frames shifted out on bps_tick.
// Start, LSB-first data, optional parity and 1-2 stop bits; back-to-back words go out gaplessly.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bps_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int CW = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 txd_q, txd_d;

  logic accept;
  logic load;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    par_d      = par_q;
    cnt_d      = cnt_q;
    txd_d      = txd_q;
    load       = 1'b0;
    accept     = tx_valid && !hold_vld_q;

    if (bps_tick) begin
      case (state_q)
        IDLE: begin
          txd_d = 1'b1;
          if (hold_vld_q) load = 1'b1;
        end
        START: begin
          state_d = DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
        DATA: begin
          // cnt_q is the index of the data bit currently on the line
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          state_d = STOP;
          txd_d   = 1'b1;
          cnt_d   = '0;
        end
        STOP: begin
          if (cnt_q == CW'(STOP_BITS - 1)) begin
            if (hold_vld_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end

    if (load) begin
      state_d    = START;
      txd_d      = 1'b0;
      shift_d    = hold_q;
      par_d      = (^hold_q) ^ (PARITY_ODD != 0);
      hold_vld_d = 1'b0;
      cnt_d      = '0;
    end

    // load needs a full holding register and accept an empty one, so they never collide
    if (accept) begin
      hold_d     = tx_data;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
      txd_q      <= txd_d;
    end
  end

  assign tx_ready = !hold_vld_q;
  assign txd      = txd_q;
  assign busy     = (state_q != IDLE) || hold_vld_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E2, 8O1) checked every cycle against a frame-level model,
// plus literal line sequences captured once per bit period.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bps_tick;
  logic [7:0] tx_data [3];
  logic [2:0] tx_valid;
  logic [2:0] tx_ready;
  logic [2:0] txd;
  logic [2:0] busy;

  int errors = 0;
  int checks = 0;
  int period = 4;
  int tcnt   = 0;

  always #5 clk = ~clk;

  uart_tx u0 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0])
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1])
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data[2]),
    .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic bit pen(input int i);  return i != 0; endfunction
  function automatic bit podd(input int i); return i == 2; endfunction
  function automatic int nstop(input int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int flen(input int i);
    return 1 + 8 + int'(pen(i)) + nstop(i);
  endfunction

  // whole frame as line levels, bit k = k-th bit period
  function automatic logic [11:0] mkframe(input int i, input logic [7:0] d);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (pen(i)) f[9] = (^d) ^ podd(i);
    return f;
  endfunction

  logic        m_full  [3];
  logic [7:0]  m_hold  [3];
  logic        m_act   [3];
  int          m_pos   [3];
  logic [11:0] m_frame [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_full[i]  <= 1'b0;
        m_hold[i]  <= '0;
        m_act[i]   <= 1'b0;
        m_pos[i]   <= 0;
        m_frame[i] <= '1;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bps_tick) begin
          if (m_act[i] && m_pos[i] < flen(i) - 1) begin
            m_pos[i] <= m_pos[i] + 1;
          end else if (m_full[i]) begin
            m_frame[i] <= mkframe(i, m_hold[i]);
            m_pos[i]   <= 0;
            m_act[i]   <= 1'b1;
            m_full[i]  <= 1'b0;
          end else begin
            m_act[i] <= 1'b0;
          end
        end
        if (tx_valid[i] && !m_full[i]) begin
          m_hold[i] <= tx_data[i];
          m_full[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("txd%0d", i), 32'(txd[i]), 32'(m_act[i] ? m_frame[i][m_pos[i]] : 1'b1));
      chk($sformatf("ready%0d", i), 32'(tx_ready[i]), 32'(!m_full[i]));
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_act[i] || m_full[i]));
    end
  end

  // ---------------- per-bit-period line log ----------------
  logic tick_seen = 1'b0;
  bit lq0[$];
  bit lq1[$];
  bit lq2[$];

  always @(posedge clk) tick_seen <= bps_tick;

  always @(negedge clk) begin
    if (tick_seen) begin
      lq0.push_back(txd[0]);
      lq1.push_back(txd[1]);
      lq2.push_back(txd[2]);
    end
  end

  task automatic clear_logs();
    lq0.delete();
    lq1.delete();
    lq2.delete();
  endtask

  // compares n bit periods starting at the first start bit in the log
  task automatic check_seq(input int i, input string name, input logic [31:0] exp, input int n);
    bit q[$];
    int s;
    logic [31:0] got;
    case (i)
      0:       q = lq0;
      1:       q = lq1;
      default: q = lq2;
    endcase
    s   = -1;
    got = '0;
    for (int k = 0; k < q.size(); k++)
      if (q[k] == 1'b0 && s < 0) s = k;
    for (int k = 0; k < n; k++)
      got[k] = (s >= 0 && s + k < q.size()) ? q[s + k] : 1'bx;
    chk(name, got, exp);
  endtask

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    tcnt     = tcnt + 1;
    bps_tick = (tcnt % period == 0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_period(input int p);
    period = p;
    tcnt   = 0;
  endtask

  task automatic send(input int i, input logic [7:0] d);
    int n;
    n           = 0;
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
    while (!tx_ready[i] && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: unit %0d word %h never accepted", i, d);
    end
    step();
    tx_valid[i] = 1'b0;
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    bps_tick = 1'b0;
    tx_valid = '0;
    for (int i = 0; i < 3; i++) tx_data[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd[0]), 32'd1);
    chk("rst_ready", 32'(tx_ready[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    rst_n = 1'b1;
    set_period(4);
    run(8);

    // single 8N1 frame
    clear_logs();
    send(0, 8'hA5);
    n = 0;
    while (txd[0] && n < 20) begin step(); n++; end
    chk("a5_ready_after_load", 32'(tx_ready[0]), 32'd1);
    chk("a5_busy_in_frame", 32'(busy[0]), 32'd1);
    run(60);
    chk("a5_busy_after", 32'(busy[0]), 32'd0);
    check_seq(0, "a5_seq", 32'h34A, 10);

    // back-to-back
    clear_logs();
    send(0, 8'h00);
    send(0, 8'hFF);
    run(100);
    check_seq(0, "b2b_seq", 32'hFFA00, 20);

    // even parity, two stop bits, back-to-back
    clear_logs();
    send(1, 8'h07);
    send(1, 8'h01);
    run(120);
    check_seq(1, "even2_seq", 32'hE02E0E, 24);

    // odd parity
    clear_logs();
    send(2, 8'h07);
    run(60);
    check_seq(2, "odd_seq", 32'h40E, 11);

    // accept coincident with tick while idle
    clear_logs();
    n = 0;
    while (!bps_tick && n < 20) begin step(); n++; end
    tx_data[0]  = 8'h3C;
    tx_valid[0] = 1'b1;
    step();
    tx_valid[0] = 1'b0;
    chk("coinc_txd_idle", 32'(txd[0]), 32'd1);
    chk("coinc_busy", 32'(busy[0]), 32'd1);
    n = 0;
    while (txd[0] && n < 20) begin step(); n++; end
    chk("coinc_latency", 32'(n), 32'd4);
    run(60);
    check_seq(0, "coinc_seq", 32'h278, 10);

    // reset in data bit 3 of 0x55
    send(0, 8'h55);
    n = 0;
    while (txd[0] && n < 20) begin step(); n++; end
    run(17);
    chk("pre_rst_txd", 32'(txd[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_txd", 32'(txd[0]), 32'd1);
    chk("arst_ready", 32'(tx_ready[0]), 32'd1);
    chk("arst_busy", 32'(busy[0]), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(12);
    chk("post_rst_idle", 32'(txd[0]), 32'd1);
    clear_logs();
    send(0, 8'h81);
    run(60);
    check_seq(0, "post_rst_seq", 32'h302, 10);

    // backpressure: holding register full, different word ignored
    clear_logs();
    send(0, 8'h12);
    send(0, 8'h34);
    tx_data[0]  = 8'h99;
    tx_valid[0] = 1'b1;
    repeat (20) begin
      step();
      chk("bp_ready_low", 32'(tx_ready[0]), 32'd0);
    end
    tx_valid[0] = 1'b0;
    run(100);
    check_seq(0, "bp_seq", 32'h9A224, 20);

    // tick held high: one bit per clk
    set_period(1);
    run(2);
    clear_logs();
    send(0, 8'hC3);
    run(20);
    check_seq(0, "cont_seq", 32'h386, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that consumes the one-cycle baud tick produced by the baud-rate divider and shifts parallel bytes out on `txd` as asynchronous UART frames (start, data LSB-first, optional parity, 1 or 2 stop bits). A one-entry holding register behind a valid/ready handshake lets the upstream producer queue the next word while the current frame is on the line, so consecutive frames go out with no idle gap.

## Interface
- `DATA_BITS`, 8: data bits per frame (5..9).
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity (only used when `PARITY_EN`=1).
- `STOP_BITS`, 1: number of stop bits (1 or 2).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bps_tick`  in  1  one-`clk`-wide pulse, once per bit period, from the baud divider.
- `tx_data`  in  DATA_BITS  word to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`  in  1  upstream has a word; must hold `tx_data` stable until accepted.
- `tx_ready`  out  1  holding register empty (`!hold_valid`).
- `txd`  out  1  serial line, idle high.
- `busy`  out  1  frame on line or word pending in holding register.

## Operation
- Reset values: `txd`=1, `tx_ready`=1, `busy`=0, state IDLE, holding register empty, bit counter 0.
- Handshake: on a `clk` edge where `tx_valid && tx_ready`, `tx_data` goes into the holding register and `hold_valid` is set. `tx_valid` while `tx_ready`=0 is ignored.
- The shifter state only changes on cycles with `bps_tick`=1. It uses these states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `txd`=1.
  - On a tick with `hold_valid`=1: move the holding register into the shift register, clear `hold_valid`, go to START, and drive `txd`=0.
- START: on the next tick, go to DATA and drive bit 0.
- DATA: each tick shifts out the next bit, LSB first.
  - After `DATA_BITS` bits, go to PARITY if `PARITY_EN`=1, otherwise to STOP.
- PARITY: drive XOR of the data word, inverted when `PARITY_ODD`=1.
  - On the next tick, go to STOP.
- STOP: `txd`=1 for `STOP_BITS` ticks.
  - On the tick that ends the last stop bit, if `hold_valid`=1, reload and go directly to START with `txd`=0 (gapless).
  - Otherwise go to IDLE.
- Parity is computed from the word as captured at load time. It is not affected by later holding-register writes.
- `busy` = (state != IDLE) || `hold_valid`.
- Boundary: accept and `bps_tick` in the same cycle while IDLE with holding register empty. The word enters the holding register at that edge; it does not start a frame on that tick. The start bit begins on the next tick.
- Boundary: a word accepted during STOP before the final tick is sent gaplessly. A word accepted in the same cycle as the final stop tick is not; the shifter goes IDLE and starts on the following tick.
- Reset mid-frame: frame aborted immediately (asynchronous). `txd`=1, the holding register is discarded, and no partial bits resume after reset release.

## Timing
- `txd` is a register output and changes only on `clk` edges where `bps_tick`=1. Each bit lasts exactly one tick period.
- Frame length: 1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS` tick periods.
- Latency, accept to start-bit edge: from 1 `clk` up to 1 tick period plus 1 `clk` when idle. It is determined by the next `bps_tick` after the accept edge.
- `tx_ready` rises the cycle after the tick that loads the shifter. The producer can therefore always refill during the current frame.
- Throughput with `tx_valid` held high: one frame per frame length, with zero idle ticks between frames.
- `bps_tick` held high continuously: the block advances one bit per `clk`. This must be legal and must produce a correct frame.

## Test plan
- Single frame, 8N1: `bps_tick` every 4 cycles; send 0xA5 -> `txd` sequence is 0, 1,0,1,0,0,1,0,1, then 1.
  - Each level lasts 4 cycles; `tx_ready` is high again one cycle after the start-bit tick; `busy` falls after the stop-bit tick.
- Back-to-back: `tx_valid` held high with 0x00 then 0xFF -> 20 consecutive bit periods 0,00000000,1,0,11111111,1, with no idle high between frames.
- Parity: `PARITY_EN`=1, even, send 0x07 -> parity bit 1; odd, send 0x07 -> parity bit 0; `STOP_BITS`=2 -> two high bit periods before the next start bit.
- Accept coincident with `bps_tick` in IDLE, word 0x3C -> `txd` stays 1 on that tick and the start bit begins on the following tick.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x55 -> `txd`=1, `tx_ready`=1, `busy`=0 asynchronously.
  - After release, a new word 0x81 is sent as a complete, correct frame.
- Backpressure: while the holding register is full, drive `tx_valid` with a different word -> `tx_ready`=0, the word is ignored, and the frame on the line is unaffected.
